id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage MIPS core.
- Consumes the decoder's control bundles (ex[3:0], mem[2:0], wb[1:0]) and the ID-stage operands, and registers them for the EX stage.
- Embeds load-use hazard detection: it raises a stall to hold PC and IF/ID, and inserts a bubble.
- Honours a branch flush from MEM and the debug unit's global step enable.

Parameters:
DATA_WIDTH, 32, operand/immediate/PC width
REG_ADDR, 5, register-index width
SIZEOP, 6, opcode width

Ports:
i_clock  in  1  single clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_enable  in  1  debug-unit step enable; 0 freezes all state
i_flush  in  1  branch taken in MEM; squash instruction entering EX
i_ex  in  4  {RegDst, ALUSrc, ALUOp[1:0]}
i_mem  in  3  {MemRead, MemWrite, Branch}
i_wb  in  2  {RegWrite, ResultSel (1=ALU, 0=memory)}
i_opcode  in  SIZEOP  ID-stage instruction[31:26]
i_pc4  in  DATA_WIDTH  PC+4 of ID instruction
i_rs_data  in  DATA_WIDTH  register file read port A
i_rt_data  in  DATA_WIDTH  register file read port B
i_imm  in  DATA_WIDTH  sign-extended immediate
i_rs  in  REG_ADDR  instruction[25:21]
i_rt  in  REG_ADDR  instruction[20:16]
i_rd  in  REG_ADDR  instruction[15:11]
o_stall  out  1  combinational; 1 = hold PC and IF/ID
o_ex  out  4  registered control to EX
o_mem  out  3  registered control to MEM
o_wb  out  2  registered control to WB
o_pc4  out  DATA_WIDTH  registered
o_rs_data  out  DATA_WIDTH  registered
o_rt_data  out  DATA_WIDTH  registered
o_imm  out  DATA_WIDTH  registered
o_rs  out  REG_ADDR  registered
o_rt  out  REG_ADDR  registered
o_rd  out  REG_ADDR  registered

Behaviour:
- Reset (i_reset=0, asynchronous): all registered outputs go to 0; the EX stage therefore holds a NOP bubble. o_stall=0 while in reset.
- Hazard detection (combinational, from the current registered state and ID inputs):
  - o_stall = o_mem[2] & (o_rt != 0) & ((o_rt == i_rs) | (uses_rt & o_rt == i_rt)).
  - uses_rt = 1 for opcodes 000000, 101011, 000100; otherwise 0.
  - o_stall is independent of i_enable and i_flush.
- Per rising edge, evaluated in this priority order:
  1. i_enable=0: every register holds its value.
  2. i_flush=1: o_ex, o_mem, o_wb load 0; data/index registers load their inputs. i_flush overrides stall.
  3. o_stall=1: control loads 0 (bubble); data/index registers load their inputs (don't-care).
  4. Otherwise: every register loads its input.
- Latency: exactly 1 cycle from ID inputs to outputs.
- A stall lasts exactly one cycle, because the bubble clears o_mem[2]. Back-to-back loads feeding each other stall once per pair.
- Don't-care (x) control bits from the decoder (SW, BEQ) propagate unmodified. Benches must not compare them.
- Reset asserted mid-stall clears o_stall within the same cycle, because o_mem clears asynchronously.

Optional Feature:
- Macro: HAZARD_COUNT_EN.
- When defined:
  - Adds output o_stall_count[31:0].
  - Increments on each rising edge where i_enable=1 & o_stall=1 & i_flush=0, and saturates at 0xFFFFFFFF.
  - Reset value is 0.
  - Read by the debug unit.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package / header holds:
  - Opcode constants (R_TYPE, LW, SW, BEQ).
  - Control bundle widths (EX_W=4, MEM_W=3, WB_W=2).
  - Bit-index constants (MEM_READ_BIT=2, REG_WRITE_BIT=1, etc.).
- One natural sub-module: hazard_detect. It is purely combinational and produces o_stall. The pipeline registers remain in id_ex_stage.

Test Plan:
1. Reset with i_reset=0 and random inputs -> all outputs 0, o_stall=0; after release, with i_enable=1, an R-type (ex=1010, wb=11, rs=3, rt=4, rd=5) appears at outputs one cycle later.
2. LW loaded with o_rt=8; next ID instruction R-type with i_rt=8 -> o_stall=1 that cycle; next edge outputs o_ex=0, o_mem=0, o_wb=0; o_stall=0 on the following cycle.
3. LW with o_rt=0, then ID rs=0 -> o_stall=0, with no bubble inserted.
4. LW with o_rt=9, then ID LW (opcode 100011) with i_rt=9 and i_rs=2 -> o_stall=0, because rt is not a source.
5. i_flush=1 together with a stall condition -> control outputs 0 and data outputs load the inputs; with i_enable=0 for 3 cycles -> outputs unchanged.
6. With HAZARD_COUNT_EN defined, 4 separate load-use stalls plus 1 stall during i_enable=0 -> o_stall_count=4.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared opcodes, control bundle widths and bit indices for the ID/EX stage
package id_ex_stage_pkg;

  localparam int EX_W  = 4;
  localparam int MEM_W = 3;
  localparam int WB_W  = 2;

  // ex = {RegDst, ALUSrc, ALUOp[1:0]}, mem = {MemRead, MemWrite, Branch}, wb = {RegWrite, ResultSel}
  localparam int REG_DST_BIT    = 3;
  localparam int ALU_SRC_BIT    = 2;
  localparam int MEM_READ_BIT   = 2;
  localparam int MEM_WRITE_BIT  = 1;
  localparam int BRANCH_BIT     = 0;
  localparam int REG_WRITE_BIT  = 1;
  localparam int RESULT_SEL_BIT = 0;

  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// rtl/id_ex_stage_hazard_detect.sv - combinational load-use hazard detection
// Stalls when the load in EX writes a register the ID instruction reads.
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_ADDR = 5,
  parameter int SIZEOP   = 6
) (
  input  logic                i_ex_mem_read,
  input  logic [REG_ADDR-1:0] i_ex_rt,
  input  logic [REG_ADDR-1:0] i_id_rs,
  input  logic [REG_ADDR-1:0] i_id_rt,
  input  logic [SIZEOP-1:0]   i_id_opcode,
  output logic                o_stall
);

  logic uses_rt;

  always_comb begin
    // Only R-type, SW and BEQ read rt as a source; loads/immediates write it.
    uses_rt = (i_id_opcode == SIZEOP'(OP_R_TYPE)) |
              (i_id_opcode == SIZEOP'(OP_SW))     |
              (i_id_opcode == SIZEOP'(OP_BEQ));
    o_stall = i_ex_mem_read & (i_ex_rt != '0) &
              ((i_ex_rt == i_id_rs) | (uses_rt & (i_ex_rt == i_id_rt)));
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion and branch flush
// Optional HAZARD_COUNT_EN adds a saturating stall counter on o_stall_count.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR   = 5,
  parameter int SIZEOP     = 6
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_flush,
  input  logic [EX_W-1:0]       i_ex,
  input  logic [MEM_W-1:0]      i_mem,
  input  logic [WB_W-1:0]       i_wb,
  input  logic [SIZEOP-1:0]     i_opcode,
  input  logic [DATA_WIDTH-1:0] i_pc4,
  input  logic [DATA_WIDTH-1:0] i_rs_data,
  input  logic [DATA_WIDTH-1:0] i_rt_data,
  input  logic [DATA_WIDTH-1:0] i_imm,
  input  logic [REG_ADDR-1:0]   i_rs,
  input  logic [REG_ADDR-1:0]   i_rt,
  input  logic [REG_ADDR-1:0]   i_rd,
  output logic                  o_stall,
  output logic [EX_W-1:0]       o_ex,
  output logic [MEM_W-1:0]      o_mem,
  output logic [WB_W-1:0]       o_wb,
  output logic [DATA_WIDTH-1:0] o_pc4,
  output logic [DATA_WIDTH-1:0] o_rs_data,
  output logic [DATA_WIDTH-1:0] o_rt_data,
  output logic [DATA_WIDTH-1:0] o_imm,
  output logic [REG_ADDR-1:0]   o_rs,
  output logic [REG_ADDR-1:0]   o_rt,
  output logic [REG_ADDR-1:0]   o_rd
`ifdef HAZARD_COUNT_EN
  ,
  output logic [31:0]           o_stall_count
`endif
);

  logic [EX_W-1:0]       ex_q, ex_d;
  logic [MEM_W-1:0]      mem_q, mem_d;
  logic [WB_W-1:0]       wb_q, wb_d;
  logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
  logic [DATA_WIDTH-1:0] rs_data_q, rs_data_d;
  logic [DATA_WIDTH-1:0] rt_data_q, rt_data_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [REG_ADDR-1:0]   rs_q, rs_d;
  logic [REG_ADDR-1:0]   rt_q, rt_d;
  logic [REG_ADDR-1:0]   rd_q, rd_d;
  logic                  stall;

  hazard_detect #(
    .REG_ADDR (REG_ADDR),
    .SIZEOP   (SIZEOP)
  ) u_hazard_detect (
    .i_ex_mem_read (mem_q[MEM_READ_BIT]),
    .i_ex_rt       (rt_q),
    .i_id_rs       (i_rs),
    .i_id_rt       (i_rt),
    .i_id_opcode   (i_opcode),
    .o_stall       (stall)
  );

  always_comb begin
    ex_d      = ex_q;
    mem_d     = mem_q;
    wb_d      = wb_q;
    pc4_d     = pc4_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    if (i_enable) begin
      pc4_d     = i_pc4;
      rs_data_d = i_rs_data;
      rt_data_d = i_rt_data;
      imm_d     = i_imm;
      rs_d      = i_rs;
      rt_d      = i_rt;
      rd_d      = i_rd;
      // Flush and stall both turn the EX slot into a bubble by zeroing control only.
      if (i_flush || stall) begin
        ex_d  = '0;
        mem_d = '0;
        wb_d  = '0;
      end else begin
        ex_d  = i_ex;
        mem_d = i_mem;
        wb_d  = i_wb;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      pc4_q     <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      pc4_q     <= pc4_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
    end
  end

`ifdef HAZARD_COUNT_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (i_enable && stall && !i_flush && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign o_stall_count = stall_count_q;
`endif

  assign o_stall   = stall;
  assign o_ex      = ex_q;
  assign o_mem     = mem_q;
  assign o_wb      = wb_q;
  assign o_pc4     = pc4_q;
  assign o_rs_data = rs_data_q;
  assign o_rt_data = rt_data_q;
  assign o_imm     = imm_q;
  assign o_rs      = rs_q;
  assign o_rt      = rt_q;
  assign o_rd      = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed-vector bench for id_ex_stage (HAZARD_COUNT_EN checks when defined)
module tb_id_ex_stage;

  localparam logic [5:0] OP_R  = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  localparam logic [3:0] EX_R  = 4'b1010;
  localparam logic [3:0] EX_LS = 4'b0100;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_enable = 1'b1;
  logic        i_flush = 1'b0;
  logic [3:0]  i_ex = '0;
  logic [2:0]  i_mem = '0;
  logic [1:0]  i_wb = '0;
  logic [5:0]  i_opcode = '0;
  logic [31:0] i_pc4 = '0;
  logic [31:0] i_rs_data = '0;
  logic [31:0] i_rt_data = '0;
  logic [31:0] i_imm = '0;
  logic [4:0]  i_rs = '0;
  logic [4:0]  i_rt = '0;
  logic [4:0]  i_rd = '0;
  logic        o_stall;
  logic [3:0]  o_ex;
  logic [2:0]  o_mem;
  logic [1:0]  o_wb;
  logic [31:0] o_pc4;
  logic [31:0] o_rs_data;
  logic [31:0] o_rt_data;
  logic [31:0] o_imm;
  logic [4:0]  o_rs;
  logic [4:0]  o_rt;
  logic [4:0]  o_rd;
`ifdef HAZARD_COUNT_EN
  logic [31:0] o_stall_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  id_ex_stage dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_enable  (i_enable),
    .i_flush   (i_flush),
    .i_ex      (i_ex),
    .i_mem     (i_mem),
    .i_wb      (i_wb),
    .i_opcode  (i_opcode),
    .i_pc4     (i_pc4),
    .i_rs_data (i_rs_data),
    .i_rt_data (i_rt_data),
    .i_imm     (i_imm),
    .i_rs      (i_rs),
    .i_rt      (i_rt),
    .i_rd      (i_rd),
    .o_stall   (o_stall),
    .o_ex      (o_ex),
    .o_mem     (o_mem),
    .o_wb      (o_wb),
    .o_pc4     (o_pc4),
    .o_rs_data (o_rs_data),
    .o_rt_data (o_rt_data),
    .o_imm     (o_imm),
    .o_rs      (o_rs),
    .o_rt      (o_rt),
    .o_rd      (o_rd)
`ifdef HAZARD_COUNT_EN
    ,
    .o_stall_count (o_stall_count)
`endif
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Data operands are derived from pc4 so each instruction carries distinct payload.
  task automatic drive(input logic [3:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                       input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] pc4);
    i_ex      = ex;
    i_mem     = mem;
    i_wb      = wb;
    i_opcode  = op;
    i_rs      = rs;
    i_rt      = rt;
    i_rd      = rd;
    i_pc4     = pc4;
    i_rs_data = pc4 ^ 32'h0001_0000;
    i_rt_data = pc4 ^ 32'h0002_0000;
    i_imm     = pc4 ^ 32'h0003_0000;
  endtask

  task automatic load_lw(input logic [4:0] rt, input logic [31:0] pc4);
    drive(EX_LS, 3'b100, 2'b10, OP_LW, 5'd1, rt, 5'd0, pc4);
    tick();
  endtask

  initial begin
    // Reset with random inputs
    drive(4'($urandom), 3'($urandom), 2'($urandom), 6'($urandom), 5'($urandom),
          5'($urandom), 5'($urandom), $urandom);
    #2 i_reset = 1'b0;
    tick();
    tick();
    chk("rst_ex", 32'(o_ex), 32'd0);
    chk("rst_mem", 32'(o_mem), 32'd0);
    chk("rst_wb", 32'(o_wb), 32'd0);
    chk("rst_pc4", o_pc4, 32'd0);
    chk("rst_rs_data", o_rs_data, 32'd0);
    chk("rst_rt_data", o_rt_data, 32'd0);
    chk("rst_imm", o_imm, 32'd0);
    chk("rst_idx", {17'd0, o_rs, o_rt, o_rd}, 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
`ifdef HAZARD_COUNT_EN
    chk("rst_count", o_stall_count, 32'd0);
`endif

    // R-type passes through with one cycle latency
    i_reset = 1'b1;
    drive(EX_R, 3'b000, 2'b11, OP_R, 5'd3, 5'd4, 5'd5, 32'h0000_0104);
    #1;
    chk("r_latency_ex", 32'(o_ex), 32'd0);
    tick();
    chk("r_ex", 32'(o_ex), 32'(EX_R));
    chk("r_mem", 32'(o_mem), 32'd0);
    chk("r_wb", 32'(o_wb), 32'd3);
    chk("r_idx", {17'd0, o_rs, o_rt, o_rd}, {17'd0, 5'd3, 5'd4, 5'd5});
    chk("r_pc4", o_pc4, 32'h0000_0104);
    chk("r_rs_data", o_rs_data, 32'h0001_0104);
    chk("r_rt_data", o_rt_data, 32'h0002_0104);
    chk("r_imm", o_imm, 32'h0003_0104);

    // Load-use on rt: one bubble, then the instruction proceeds
    load_lw(5'd8, 32'h0000_0108);
    chk("lw_mem", 32'(o_mem), 32'b100);
    drive(EX_R, 3'b000, 2'b11, OP_R, 5'd7, 5'd8, 5'd9, 32'h0000_010C);
    #1;
    chk("lu_stall", 32'(o_stall), 32'd1);
    tick();
    chk("lu_bubble_ctl", {25'd0, o_ex, o_mem, o_wb}, 32'd0);
    chk("lu_bubble_rt", 32'(o_rt), 32'd8);
    chk("lu_stall_clear", 32'(o_stall), 32'd0);
    tick();
    chk("lu_reissue_ex", 32'(o_ex), 32'(EX_R));
    chk("lu_reissue_wb", 32'(o_wb), 32'd3);

    // Load to $zero never stalls
    load_lw(5'd0, 32'h0000_0110);
    drive(EX_R, 3'b000, 2'b11, OP_R, 5'd0, 5'd0, 5'd6, 32'h0000_0114);
    #1;
    chk("zero_stall", 32'(o_stall), 32'd0);
    tick();
    chk("zero_no_bubble", 32'(o_ex), 32'(EX_R));

    // LW after LW on the same rt: rt is a destination, no stall
    load_lw(5'd9, 32'h0000_0118);
    drive(EX_LS, 3'b100, 2'b10, OP_LW, 5'd2, 5'd9, 5'd0, 32'h0000_011C);
    #1;
    chk("lwlw_stall", 32'(o_stall), 32'd0);
    tick();
    chk("lwlw_mem", 32'(o_mem), 32'b100);
    chk("lwlw_rt", 32'(o_rt), 32'd9);

    // Flush together with a stall: control zeroed, data loads
    drive(EX_LS, 3'b010, 2'b00, OP_SW, 5'd4, 5'd9, 5'd0, 32'h0000_0AA0);
    i_flush = 1'b1;
    #1;
    chk("flush_stall_seen", 32'(o_stall), 32'd1);
    tick();
    i_flush = 1'b0;
    chk("flush_ctl", {25'd0, o_ex, o_mem, o_wb}, 32'd0);
    chk("flush_pc4", o_pc4, 32'h0000_0AA0);
    chk("flush_rt_data", o_rt_data, 32'h0002_0AA0);
    chk("flush_rs", 32'(o_rs), 32'd4);

    // SW after LW: rt is a source, stall (counted)
    load_lw(5'd10, 32'h0000_0120);
    drive(EX_LS, 3'b010, 2'b00, OP_SW, 5'd4, 5'd10, 5'd0, 32'h0000_0124);
    #1;
    chk("sw_stall", 32'(o_stall), 32'd1);
    tick();
    chk("sw_bubble_mem", 32'(o_mem), 32'd0);

    // Freeze with a stall pending: nothing moves, nothing counted
    load_lw(5'd8, 32'h0000_0130);
    i_enable = 1'b0;
    drive(EX_R, 3'b000, 2'b11, OP_R, 5'd8, 5'd2, 5'd3, 32'h0000_0BB0);
    #1;
    chk("frz_stall", 32'(o_stall), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("frz_ex", 32'(o_ex), 32'(EX_LS));
    chk("frz_mem", 32'(o_mem), 32'b100);
    chk("frz_rt", 32'(o_rt), 32'd8);
    chk("frz_pc4", o_pc4, 32'h0000_0130);
    i_enable = 1'b1;
    tick();
    chk("unfrz_bubble", {25'd0, o_ex, o_mem, o_wb}, 32'd0);
    chk("unfrz_pc4", o_pc4, 32'h0000_0BB0);

    // Fourth counted stall via rs
    load_lw(5'd12, 32'h0000_0140);
    drive(EX_R, 3'b000, 2'b11, OP_R, 5'd12, 5'd1, 5'd2, 32'h0000_0144);
    #1;
    chk("rs_stall", 32'(o_stall), 32'd1);
    tick();
    chk("rs_bubble", 32'(o_ex), 32'd0);
`ifdef HAZARD_COUNT_EN
    chk("stall_count", o_stall_count, 32'd4);
`endif

    // Reset asserted mid-stall clears o_stall without a clock edge
    load_lw(5'd13, 32'h0000_0150);
    drive(EX_R, 3'b000, 2'b11, OP_R, 5'd13, 5'd1, 5'd2, 32'h0000_0154);
    #1;
    chk("pre_rst_stall", 32'(o_stall), 32'd1);
    i_reset = 1'b0;
    #1;
    chk("async_rst_stall", 32'(o_stall), 32'd0);
    chk("async_rst_mem", 32'(o_mem), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
